// File: rtl/reg_arb_pkg.sv
// Shared constants for the register-bank write arbiter.
// Defaults, address-width helper and requester index names.
package reg_arb_pkg;

  localparam int DEF_WIDTH      = 16;
  localparam int DEF_NREQ       = 3;
  localparam int DEF_NREGS      = 8;
  localparam int DEF_PROTECT_R0 = 1;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_IMM = 2;

  // Index width for n items, never below 1 bit.
  function automatic int addr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority picker: first set request at or above i_ptr, wrapping.
// Ports: i_req, i_ptr in; o_gnt (one-hot), o_idx (encoded) out.
module rr_arbiter #(
  parameter  int N  = 3,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [PW-1:0] o_idx
);

  int w_dist;
  int w_best;

  // Distance from the pointer decides priority;
  // the requester closest above it wins.
  always_comb begin
    w_dist = 0;
    w_best = N;
    o_idx  = '0;
    for (int i = 0; i < N; i++) begin
      if (i >= int'(i_ptr))
        w_dist = i - int'(i_ptr);
      else
        w_dist = i + N - int'(i_ptr);
      if (i_req[i] && (w_dist < w_best)) begin
        w_best = w_dist;
        o_idx  = PW'(i);
      end
    end
  end

  always_comb begin
    o_gnt = '0;
    for (int i = 0; i < N; i++)
      o_gnt[i] = (w_best < N) && (o_idx == PW'(i));
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port.
// Ports: clk, rst_n, stall, req/req_addr/req_data in; gnt, busy (comb),
// reg_en, reg_set, wr_data (registered, one cycle after the grant) out.
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter  int WIDTH      = DEF_WIDTH,
  parameter  int NREQ       = DEF_NREQ,
  parameter  int NREGS      = DEF_NREGS,
  parameter  int PROTECT_R0 = DEF_PROTECT_R0,
  localparam int AW         = addr_w(NREGS),
  localparam int PW         = addr_w(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*AW-1:0]    req_addr,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  output logic [NREGS-1:0]      reg_en,
  output logic                  reg_set,
  output logic [WIDTH-1:0]      wr_data,
  output logic                  busy
);

  logic [PW-1:0]    r_ptr;
  logic [NREGS-1:0] r_en;
  logic             r_set;
  logic [WIDTH-1:0] r_data;

  logic [NREQ-1:0]  w_gnt_raw;
  logic [NREQ-1:0]  w_gnt;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_any;
  logic [AW-1:0]    w_sel_addr;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_addr_ok;
  logic [NREGS-1:0] w_dec;

  rr_arbiter #(
    .N(NREQ)
  ) u_rr (
    .i_req(req),
    .i_ptr(r_ptr),
    .o_gnt(w_gnt_raw),
    .o_idx(w_idx)
  );

  // Grant is suppressed during reset as well as stall.
  assign w_gnt = (rst_n && !stall) ? w_gnt_raw : '0;
  assign w_any = |w_gnt;

  assign w_ptr_nxt = (w_idx == PW'(NREQ - 1))
                   ? '0
                   : w_idx + PW'(1);

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_sel_addr = req_addr[i*AW +: AW];
        w_sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Out-of-range and protected-R0 writes are granted but never strobed.
  assign w_addr_ok =
    ({1'b0, w_sel_addr} < (AW+1)'(NREGS)) &&
    !((PROTECT_R0 != 0) && (w_sel_addr == '0));

  always_comb begin
    w_dec = '0;
    for (int r = 0; r < NREGS; r++)
      w_dec[r] = w_addr_ok && (w_sel_addr == AW'(r));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr  <= '0;
      r_en   <= '0;
      r_set  <= 1'b0;
      r_data <= '0;
    end else if (w_any) begin
      r_ptr  <= w_ptr_nxt;
      r_en   <= w_dec;
      r_set  <= w_addr_ok;
      r_data <= w_sel_data;
    end else begin
      r_en  <= '0;
      r_set <= 1'b0;
    end
  end

  assign gnt     = w_gnt;
  assign reg_en  = r_en;
  assign reg_set = r_set;
  assign wr_data = r_data;
  assign busy    = |(req & ~w_gnt);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Self-checking bench for reg_write_arbiter: directed cases then random
// traffic compared every cycle against a queue-free behavioural model.
module tb_reg_write_arbiter;

  localparam int W  = 16;
  localparam int N  = 3;
  localparam int R  = 8;
  localparam int AW = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             stall = 1'b0;
  logic [N-1:0]     req = '0;
  logic [N*AW-1:0]  req_addr = '0;
  logic [N*W-1:0]   req_data = '0;
  logic [N-1:0]     gnt;
  logic [R-1:0]     reg_en;
  logic             reg_set;
  logic [W-1:0]     wr_data;
  logic             busy;

  reg_write_arbiter #(
    .WIDTH(W), .NREQ(N), .NREGS(R), .PROTECT_R0(1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .reg_en(reg_en), .reg_set(reg_set),
    .wr_data(wr_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total    = 0;

  // Model state: who is next in line and what the bank port shows.
  int           m_ptr  = 0;
  logic [R-1:0] m_en   = '0;
  logic         m_set  = 1'b0;
  logic [W-1:0] m_data = '0;
  int           wait_g [N];
  int           last_k;

  logic [N-1:0] cap_gnt;
  logic [R-1:0] cap_en;
  logic         cap_set;
  logic [W-1:0] cap_data;
  logic         cap_busy;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int model_pick();
    if (!rst_n || stall) return -1;
    for (int o = 0; o < N; o++) begin
      int j;
      j = (m_ptr + o) % N;
      if (req[j]) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_en = '0; m_set = 1'b0; m_data = '0;
    for (int i = 0; i < N; i++) wait_g[i] = 0;
  endtask

  // One clock: compare at negedge, advance the model at posedge.
  task automatic cycle();
    int k;
    logic [N-1:0] eg;
    @(negedge clk);
    k  = model_pick();
    eg = (k < 0) ? '0 : N'(1 << k);
    cap_gnt = gnt; cap_en = reg_en; cap_set = reg_set;
    cap_data = wr_data; cap_busy = busy;
    check("gnt", gnt, eg);
    check("busy", busy, |(req & ~eg));
    check("reg_en", reg_en, m_en);
    check("reg_set", reg_set, m_set);
    check("wr_data", wr_data, m_data);
    @(posedge clk);
    if (rst_n) begin
      if (k >= 0) begin
        int a;
        for (int i = 0; i < N; i++) begin
          if (!req[i] || i == k) begin
            if (i == k) begin
              total++;
              if (wait_g[i] <= N - 1) pass_cnt++;
              else $display("FAIL fairness: req %0d waited %0d grants", i, wait_g[i]);
            end
            wait_g[i] = 0;
          end else begin
            wait_g[i]++;
          end
        end
        m_ptr  = (k + 1) % N;
        a      = int'(req_addr[k*AW +: AW]);
        m_data = req_data[k*W +: W];
        m_set  = (a != 0) && (a < R);
        m_en   = m_set ? R'(1 << a) : '0;
      end else begin
        m_en  = '0;
        m_set = 1'b0;
      end
    end
    last_k = k;
    #1;
  endtask

  task automatic set_item(input int i, input int a, input logic [W-1:0] d);
    req_addr[i*AW +: AW] = AW'(a);
    req_data[i*W +: W]   = d;
  endtask

  initial begin
    model_reset();
    last_k = -1;
    // Reset with all requests high.
    req = 3'b111;
    set_item(0, 1, 16'h1111);
    set_item(1, 2, 16'h2222);
    set_item(2, 3, 16'h3333);
    #1;
    cycle();
    check("rst_gnt", cap_gnt, 3'b000);
    check("rst_wr_data", cap_data, 16'h0000);
    cycle();
    rst_n = 1'b1;
    // Round robin from requester 0.
    cycle();
    check("rr_g0", cap_gnt, 3'b001);
    cycle();
    check("rr_g1", cap_gnt, 3'b010);
    check("rr_d0", cap_data, 16'h1111);
    check("rr_set0", cap_set, 1'b1);
    cycle();
    check("rr_g2", cap_gnt, 3'b100);
    check("rr_d1", cap_data, 16'h2222);
    cycle();
    check("rr_wrap", cap_gnt, 3'b001);
    check("rr_d2", cap_data, 16'h3333);
    check("rr_set2", cap_set, 1'b1);
    req = '0;
    cycle();
    cycle();
    // Single write from requester 1.
    set_item(1, 5, 16'hABCD);
    req = 3'b010;
    cycle();
    check("single_gnt", cap_gnt, 3'b010);
    req = '0;
    cycle();
    check("single_en", cap_en, 8'b0010_0000);
    check("single_set", cap_set, 1'b1);
    check("single_data", cap_data, 16'hABCD);
    cycle();
    check("single_set_drop", cap_set, 1'b0);
    // Stall blocks grants.
    set_item(0, 4, 16'h5A5A);
    req = 3'b001;
    stall = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle();
      check("stall_gnt", cap_gnt, 3'b000);
      check("stall_busy", cap_busy, 1'b1);
    end
    stall = 1'b0;
    cycle();
    check("unstall_gnt", cap_gnt, 3'b001);
    req = '0;
    cycle();
    check("unstall_en", cap_en, 8'b0001_0000);
    check("unstall_data", cap_data, 16'h5A5A);
    // Write to R0 is discarded.
    set_item(2, 0, 16'hFFFF);
    req = 3'b100;
    cycle();
    check("r0_gnt", cap_gnt, 3'b100);
    req = '0;
    cycle();
    check("r0_en", cap_en, 8'h00);
    check("r0_set", cap_set, 1'b0);
    check("r0_data", cap_data, 16'hFFFF);
    set_item(0, 1, 16'h0101);
    set_item(1, 2, 16'h0202);
    set_item(2, 3, 16'h0303);
    req = 3'b111;
    cycle();
    check("r0_ptr", cap_gnt, 3'b001);
    req = '0;
    cycle();
    // Asynchronous reset while a write is registered.
    set_item(1, 6, 16'h1234);
    req = 3'b010;
    cycle();
    req = '0;
    check("pre_rst_set", reg_set, 1'b1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_set", reg_set, 1'b0);
    check("async_en", reg_en, 8'h00);
    cycle();
    rst_n = 1'b1;
    cycle();
    check("post_rst_set", cap_set, 1'b0);
    req = 3'b111;
    cycle();
    check("post_rst_ptr", cap_gnt, 3'b001);
    req = '0;
    cycle();
    // Random traffic; requests stay stable until granted.
    for (int n = 0; n < 600; n++) begin
      for (int i = 0; i < N; i++) begin
        if (i == last_k) begin
          if ($urandom_range(0, 1) == 1) begin
            set_item(i, $urandom_range(0, R-1), W'($urandom));
          end else begin
            req[i] = 1'b0;
          end
        end else if (!req[i] && $urandom_range(0, 9) < 4) begin
          set_item(i, $urandom_range(0, R-1), W'($urandom));
          req[i] = 1'b1;
        end
      end
      stall = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 149) == 0) begin
        rst_n = 1'b0;
        model_reset();
        cycle();
        rst_n = 1'b1;
      end
      cycle();
    end
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
